rf_sequencer: RTL and testbench

Command-driven access controller that sits in front of the 8×16-bit register file and drives its write/read port (writenum, readnum, write, data_in, data_out). Accepts one command at a time over a valid/ready handshake, performs the required register reads and the write-back as a short multi-cycle sequence, and returns a result plus status flags over a second valid/ready handshake. It is the initiator side of the register-file interface and replaces ad-hoc testbench driving of that port.

---
 rtl/rf_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_rf_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_sequencer.sv
// rf_sequencer: command-driven access controller for the 8x16 register file.
// Accepts one command at a time, performs the operand reads and the
// write-back as a short multi-cycle sequence, and returns the result with
// {N, Z, V} flags.
// Optional feature: define RF_SEQUENCER_SUB_EN to make opcode 100 a SUB.
// Without it, opcode 100 is illegal and no subtract logic is built.
module rf_sequencer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [2:0]   cmd_rd,
  input  logic [2:0]   cmd_ra,
  input  logic [2:0]   cmd_rb,
  input  logic [W-1:0] cmd_imm,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [2:0]   rsp_flags,
  output logic         rsp_err,
  output logic [2:0]   rf_writenum,
  output logic [2:0]   rf_readnum,
  output logic         rf_write,
  output logic [W-1:0] rf_data_in,
  input  logic [W-1:0] rf_data_out
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_READ = 3'b011;
`ifdef RF_SEQUENCER_SUB_EN
  localparam logic [2:0] OP_SUB  = 3'b100;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDA,
    S_RDB,
    S_WR,
    S_DONE
  } state_t;

  state_t         state, state_next;
  logic [2:0]     op_q, rd_q, ra_q, rb_q;
  logic [W-1:0]   imm_q, a_q, b_q;
  logic [W-1:0]   alu_res;
  logic           alu_v;
  logic           cmd_legal;

  // Decode which opcodes this build supports
  always_comb begin
    cmd_legal = 1'b0;
    case (cmd_op)
      OP_LOAD, OP_MOV, OP_ADD, OP_READ: cmd_legal = 1'b1;
`ifdef RF_SEQUENCER_SUB_EN
      OP_SUB:                           cmd_legal = 1'b1;
`endif
      default:                          cmd_legal = 1'b0;
    endcase
  end

  // Write-back value and signed overflow, computed only from latched fields
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (op_q)
      OP_LOAD: alu_res = imm_q;
      OP_MOV:  alu_res = a_q;
      OP_ADD: begin
        alu_res = a_q + b_q;
        alu_v   = (a_q[W-1] == b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
      end
`ifdef RF_SEQUENCER_SUB_EN
      OP_SUB: begin
        alu_res = a_q - b_q;
        alu_v   = (a_q[W-1] != b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
      end
`endif
      default: begin
        alu_res = '0;
        alu_v   = 1'b0;
      end
    endcase
  end

  // State register; reset abandons any sequence so rf_write drops at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next state and all register-file / handshake outputs from state only
  always_comb begin
    state_next  = state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rf_write    = 1'b0;
    rf_writenum = 3'd0;
    rf_readnum  = 3'd0;
    rf_data_in  = '0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (!cmd_legal)           state_next = S_DONE;
          else if (cmd_op == OP_LOAD) state_next = S_WR;
          else                      state_next = S_RDA;
        end
      end
      S_RDA: begin
        rf_readnum = ra_q;
        if (op_q == OP_MOV)       state_next = S_WR;
        else if (op_q == OP_READ) state_next = S_DONE;
        else                      state_next = S_RDB;
      end
      S_RDB: begin
        rf_readnum = rb_q;
        state_next = S_WR;
      end
      S_WR: begin
        rf_write    = 1'b1;
        rf_writenum = rd_q;
        rf_data_in  = alu_res;
        state_next  = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command fields, operands and the response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= 3'd0;
      rd_q      <= 3'd0;
      ra_q      <= 3'd0;
      rb_q      <= 3'd0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_data  <= '0;
      rsp_flags <= 3'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            ra_q  <= cmd_ra;
            rb_q  <= cmd_rb;
            imm_q <= cmd_imm;
            if (!cmd_legal) begin
              rsp_data  <= '0;
              rsp_flags <= 3'd0;
              rsp_err   <= 1'b1;
            end else begin
              rsp_err   <= 1'b0;
            end
          end
        end
        S_RDA: begin
          a_q <= rf_data_out;
          if (op_q == OP_READ) begin
            rsp_data  <= rf_data_out;
            rsp_flags <= {rf_data_out[W-1], (rf_data_out == '0), 1'b0};
          end
        end
        S_RDB: b_q <= rf_data_out;
        S_WR: begin
          rsp_data  <= alu_res;
          rsp_flags <= {alu_res[W-1], (alu_res == '0), alu_v};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_sequencer.sv
// Testbench for rf_sequencer: directed table, hand-written stall and reset
// sequences, then random commands checked against a register-file model.
module tb_rf_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op, cmd_rd, cmd_ra, cmd_rb;
  logic [15:0] cmd_imm;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_flags;
  logic        rsp_err;
  logic [2:0]  rf_writenum, rf_readnum;
  logic        rf_write;
  logic [15:0] rf_data_in, rf_data_out;

  rf_sequencer #(.W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .rf_writenum(rf_writenum), .rf_readnum(rf_readnum), .rf_write(rf_write),
    .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural register file the sequencer drives
  logic [15:0] rf_mem [8];
  int          wr_cnt = 0;
  logic [2:0]  last_wnum = 3'd0;
  assign rf_data_out = rf_mem[rf_readnum];

  always @(posedge clk) begin
    if (rf_write) begin
      rf_mem[rf_writenum] <= rf_data_in;
      wr_cnt    <= wr_cnt + 1;
      last_wnum <= rf_writenum;
    end
  end

  // Reference model state: what the register file should contain
  logic [15:0] mregs [8];
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [2:0]  op, rd, ra, rb;
    logic [15:0] imm;
    logic [15:0] exp_data;
    logic [2:0]  exp_flags;
    logic        exp_err;
    int          exp_lat;
    int          exp_nwr;
  } vec_t;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: result, flags, error, latency and write count from the opcode rules
  task automatic predict(input logic [2:0] op, rd, ra, rb, input logic [15:0] imm,
                         output logic [15:0] d, output logic [2:0] f, output logic e,
                         output int lat, output int nwr);
    int sa, sb, s;
    logic v;
    sa = int'($signed(mregs[ra]));
    sb = int'($signed(mregs[rb]));
    v = 1'b0; e = 1'b0; nwr = 0; d = 16'h0;
    case (op)
      3'd0: begin d = imm;        lat = 2; nwr = 1; end
      3'd1: begin d = mregs[ra];  lat = 3; nwr = 1; end
      3'd2: begin s = sa + sb; d = s[15:0]; v = (s > 32767) || (s < -32768); lat = 4; nwr = 1; end
      3'd3: begin d = mregs[ra];  lat = 2; end
`ifdef RF_SEQUENCER_SUB_EN
      3'd4: begin s = sa - sb; d = s[15:0]; v = (s > 32767) || (s < -32768); lat = 4; nwr = 1; end
`endif
      default: begin e = 1'b1; lat = 1; end
    endcase
    f = e ? 3'b000 : {d[15], (d == 16'h0), v};
    if (nwr == 1) mregs[rd] = d;
  endtask

  // Issue one command, wait for the response after rdy_delay cycles, consume it
  task automatic applyStimulus(input logic [2:0] op, rd, ra, rb, input logic [15:0] imm,
                               input int rdy_delay,
                               output logic [15:0] d, output logic [2:0] f, output logic e,
                               output int lat, output int nwr, output logic [2:0] wnum);
    int guard, start_wr;
    guard = 0;
    while (!cmd_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
    start_wr = wr_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    repeat (rdy_delay) begin @(posedge clk); #1; end
    d = rsp_data; f = rsp_flags; e = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    nwr = wr_cnt - start_wr;
    wnum = last_wnum;
  endtask

  task automatic checkResponse(input string tag, input logic [2:0] rd,
                               input logic [15:0] d, input logic [2:0] f, input logic e,
                               input int lat, input int nwr, input logic [2:0] wnum,
                               input logic [15:0] xd, input logic [2:0] xf, input logic xe,
                               input int xlat, input int xnwr);
    checkOutput({tag, " data"},    d, xd);
    checkOutput({tag, " flags"},   16'(f), 16'(xf));
    checkOutput({tag, " err"},     16'(e), 16'(xe));
    checkOutput({tag, " latency"}, 16'(lat), 16'(xlat));
    checkOutput({tag, " writes"},  16'(nwr), 16'(xnwr));
    if (xnwr == 1) checkOutput({tag, " writenum"}, 16'(wnum), 16'(rd));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t        vecs [13];
    logic [15:0] d, xd;
    logic [2:0]  f, xf, wnum;
    logic        e, xe;
    int          lat, xlat, nwr, xnwr, start_wr;

    for (int i = 0; i < 8; i++) begin rf_mem[i] = 16'h0; mregs[i] = 16'h0; end
    reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 3'd0; cmd_rd = 3'd0; cmd_ra = 3'd0; cmd_rb = 3'd0; cmd_imm = 16'h0;
    #1;
    checkOutput("reset cmd_ready", 16'(cmd_ready), 16'd1);
    checkOutput("reset rsp_valid", 16'(rsp_valid), 16'd0);
    checkOutput("reset rsp_data",  rsp_data, 16'h0);
    checkOutput("reset rsp_flags", 16'(rsp_flags), 16'd0);
    checkOutput("reset rsp_err",   16'(rsp_err), 16'd0);
    checkOutput("reset rf_write",  16'(rf_write), 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed table: op, rd, ra, rb, imm, data, flags{N,Z,V}, err, latency, writes
    vecs[0]  = '{3'd0, 3'd3, 3'd0, 3'd0, 16'h1234, 16'h1234, 3'b000, 1'b0, 2, 1};
    vecs[1]  = '{3'd3, 3'd0, 3'd3, 3'd0, 16'h0000, 16'h1234, 3'b000, 1'b0, 2, 0};
    vecs[2]  = '{3'd0, 3'd1, 3'd0, 3'd0, 16'h7FFF, 16'h7FFF, 3'b000, 1'b0, 2, 1};
    vecs[3]  = '{3'd0, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001, 3'b000, 1'b0, 2, 1};
    vecs[4]  = '{3'd2, 3'd4, 3'd1, 3'd2, 16'h0000, 16'h8000, 3'b101, 1'b0, 4, 1};
    vecs[5]  = '{3'd3, 3'd0, 3'd4, 3'd0, 16'h0000, 16'h8000, 3'b100, 1'b0, 2, 0};
    vecs[6]  = '{3'd1, 3'd5, 3'd4, 3'd0, 16'h0000, 16'h8000, 3'b100, 1'b0, 3, 1};
    vecs[7]  = '{3'd2, 3'd5, 3'd5, 3'd5, 16'h0000, 16'h0000, 3'b011, 1'b0, 4, 1};
    vecs[8]  = '{3'd3, 3'd0, 3'd5, 3'd0, 16'h0000, 16'h0000, 3'b010, 1'b0, 2, 0};
    vecs[9]  = '{3'd0, 3'd1, 3'd0, 3'd0, 16'h0005, 16'h0005, 3'b000, 1'b0, 2, 1};
    vecs[10] = '{3'd0, 3'd2, 3'd0, 3'd0, 16'h0007, 16'h0007, 3'b000, 1'b0, 2, 1};
`ifdef RF_SEQUENCER_SUB_EN
    vecs[11] = '{3'd4, 3'd7, 3'd1, 3'd2, 16'h0000, 16'hFFFE, 3'b100, 1'b0, 4, 1};
`else
    vecs[11] = '{3'd4, 3'd7, 3'd1, 3'd2, 16'h0000, 16'h0000, 3'b000, 1'b1, 1, 0};
`endif
    vecs[12] = '{3'd7, 3'd6, 3'd1, 3'd2, 16'h1111, 16'h0000, 3'b000, 1'b1, 1, 0};

    for (int i = 0; i < 13; i++) begin
      predict(vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb, vecs[i].imm, xd, xf, xe, xlat, xnwr);
      applyStimulus(vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb, vecs[i].imm, 0,
                    d, f, e, lat, nwr, wnum);
      checkResponse($sformatf("vec%0d", i), vecs[i].rd, d, f, e, lat, nwr, wnum,
                    vecs[i].exp_data, vecs[i].exp_flags, vecs[i].exp_err,
                    vecs[i].exp_lat, vecs[i].exp_nwr);
    end
    checkOutput("table rf r5", rf_mem[5], 16'h0000);

    // Stall in DONE for 5 cycles with a new command pending
    predict(3'd0, 3'd0, 3'd0, 3'd0, 16'hBEEF, xd, xf, xe, xlat, xnwr);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rd = 3'd0; cmd_imm = 16'hBEEF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checkOutput("stall latency", 16'(lat), 16'd2);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_ra = 3'd0; cmd_rd = 3'd1;
    for (int c = 0; c < 5; c++) begin
      checkOutput("stall rsp_valid", 16'(rsp_valid), 16'd1);
      checkOutput("stall rsp_data",  rsp_data, 16'hBEEF);
      checkOutput("stall rsp_flags", 16'(rsp_flags), 16'(3'b100));
      checkOutput("stall cmd_ready", 16'(cmd_ready), 16'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("post-hs cmd_ready", 16'(cmd_ready), 16'd1);
    checkOutput("post-hs rsp_valid", 16'(rsp_valid), 16'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checkOutput("pending read latency", 16'(lat), 16'd2);
    checkOutput("pending read data", rsp_data, mregs[0]);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset asserted during the write cycle of a LOAD
    predict(3'd0, 3'd6, 3'd0, 3'd0, 16'hAAAA, xd, xf, xe, xlat, xnwr);
    applyStimulus(3'd0, 3'd6, 3'd0, 3'd0, 16'hAAAA, 0, d, f, e, lat, nwr, wnum);
    start_wr = wr_cnt;
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rd = 3'd6; cmd_imm = 16'h5555;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("WR rf_write high", 16'(rf_write), 16'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid-reset rf_write",    16'(rf_write), 16'd0);
    checkOutput("mid-reset cmd_ready",   16'(cmd_ready), 16'd1);
    checkOutput("mid-reset rsp_valid",   16'(rsp_valid), 16'd0);
    checkOutput("mid-reset rsp_data",    rsp_data, 16'h0);
    checkOutput("mid-reset rsp_flags",   16'(rsp_flags), 16'd0);
    checkOutput("mid-reset rsp_err",     16'(rsp_err), 16'd0);
    checkOutput("mid-reset rf_writenum", 16'(rf_writenum), 16'd0);
    checkOutput("mid-reset rf_readnum",  16'(rf_readnum), 16'd0);
    checkOutput("mid-reset rf_data_in",  rf_data_in, 16'h0);
    @(posedge clk); #1;
    checkOutput("mid-reset R6 kept", rf_mem[6], mregs[6]);
    checkOutput("mid-reset no write", 16'(wr_cnt - start_wr), 16'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // Random commands against the model, random response back-pressure
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  rop, rrd, rra, rrb;
      logic [15:0] rimm;
      int          rdly;
      rop  = (i < 8) ? 3'd0 : 3'($urandom_range(0, 7));
      rrd  = 3'($urandom_range(0, 7));
      rra  = 3'($urandom_range(0, 7));
      rrb  = 3'($urandom_range(0, 7));
      rimm = 16'($urandom);
      rdly = $urandom_range(0, 2);
      predict(rop, rrd, rra, rrb, rimm, xd, xf, xe, xlat, xnwr);
      applyStimulus(rop, rrd, rra, rrb, rimm, rdly, d, f, e, lat, nwr, wnum);
      checkResponse($sformatf("rand%0d op%0d", i, rop), rrd, d, f, e, lat, nwr, wnum,
                    xd, xf, xe, xlat, xnwr);
    end
    for (int r = 0; r < 8; r++)
      checkOutput($sformatf("final R%0d", r), rf_mem[r], mregs[r]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
